// File: rtl/latch_exerciser.sv
// Sequencer that writes an 8-bit pattern into an external latch or flip-flop one bit at a time
// and reads each bit back. It counts the bits that read back wrong and reports pass or fail.
module latch_exerciser #(
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned PULSE_CYC  = 3,
   parameter int unsigned SETTLE_CYC = 4
) (
   input  logic       clk,
   input  logic       R,
   input  logic       start,
   input  logic [1:0] mode,
   input  logic [7:0] pattern,
   input  logic       lat_Q,
   output logic       lat_clk,
   output logic       lat_S,
   output logic       lat_R,
   output logic       lat_D,
   output logic       lat_rst,
   output logic       busy,
   output logic [7:0] captured,
   output logic [3:0] fail_count,
   output logic       done,
   output logic       pass
);

   typedef enum logic [2:0] {IDLE, CLEAR, SETUP, PULSE, SETTLE, CHECK, FIN} state_t;

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LD  = 4'(PULSE_CYC - 1);
   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

   state_t     state, nxt_state;
   logic [3:0] cnt, nxt_cnt;
   logic       clr_settle, nxt_clr_settle;
   logic [1:0] mode_r, nxt_mode;
   logic [7:0] pat_r, nxt_pat;
   logic [2:0] idx, nxt_idx;
   logic [7:0] nxt_captured;
   logic [3:0] nxt_fail;
   logic       nxt_pass, nxt_busy, nxt_done;
   logic       nxt_lat_clk, nxt_lat_S, nxt_lat_R, nxt_lat_D, nxt_lat_rst;
   logic       cur_bit;

   always_comb begin
      nxt_state      = state;
      nxt_cnt        = cnt;
      nxt_clr_settle = clr_settle;
      nxt_mode       = mode_r;
      nxt_pat        = pat_r;
      nxt_idx        = idx;
      nxt_captured   = captured;
      nxt_fail       = fail_count;
      nxt_pass       = pass;

      case (state)
         IDLE: begin
            if (start) begin
               nxt_mode     = mode;
               nxt_pat      = pattern;
               nxt_captured = 8'd0;
               nxt_fail     = 4'd0;
               nxt_pass     = 1'b0;
               nxt_idx      = 3'd0;
               if (mode[1]) begin
                  nxt_state      = CLEAR;
                  nxt_cnt        = PULSE_LD;
                  nxt_clr_settle = 1'b0;
               end else begin
                  nxt_state = SETUP;
                  nxt_cnt   = SETUP_LD;
               end
            end
         end
         // CLEAR runs a reset pulse followed by a quiet settle window before the first bit
         CLEAR: begin
            if (cnt != 4'd0) begin
               nxt_cnt = cnt - 4'd1;
            end else if (!clr_settle) begin
               nxt_clr_settle = 1'b1;
               nxt_cnt        = SETTLE_LD;
            end else begin
               nxt_state = SETUP;
               nxt_cnt   = SETUP_LD;
            end
         end
         SETUP: begin
            if (cnt != 4'd0) begin
               nxt_cnt = cnt - 4'd1;
            end else begin
               nxt_state = PULSE;
               nxt_cnt   = PULSE_LD;
            end
         end
         PULSE: begin
            if (cnt != 4'd0) begin
               nxt_cnt = cnt - 4'd1;
            end else begin
               nxt_state = SETTLE;
               nxt_cnt   = SETTLE_LD;
            end
         end
         SETTLE: begin
            if (cnt != 4'd0) nxt_cnt = cnt - 4'd1;
            else             nxt_state = CHECK;
         end
         CHECK: begin
            nxt_captured[idx] = lat_Q;
            if ((lat_Q != pat_r[idx]) && (fail_count != 4'd15)) nxt_fail = fail_count + 4'd1;
            if (idx == 3'd7) begin
               nxt_state = FIN;
               nxt_pass  = (nxt_fail == 4'd0);
            end else begin
               nxt_idx   = idx + 3'd1;
               nxt_state = SETUP;
               nxt_cnt   = SETUP_LD;
            end
         end
         FIN:     nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase

      // Drives are derived from the upcoming state so they register in step with it
      cur_bit     = nxt_pat[nxt_idx];
      nxt_lat_clk = (nxt_mode == 2'd0);
      nxt_lat_S   = 1'b1;
      nxt_lat_R   = 1'b1;
      nxt_lat_D   = 1'b0;
      nxt_lat_rst = 1'b0;
      nxt_busy    = 1'b1;
      nxt_done    = 1'b0;

      case (nxt_state)
         IDLE:  nxt_busy = 1'b0;
         FIN: begin
            nxt_busy = 1'b0;
            nxt_done = 1'b1;
         end
         CLEAR: nxt_lat_rst = !nxt_clr_settle;
         SETUP, SETTLE, CHECK: nxt_lat_D = (nxt_mode != 2'd0) && cur_bit;
         PULSE: begin
            if (nxt_mode == 2'd0) begin
               nxt_lat_clk = 1'b0;
               nxt_lat_S   = !cur_bit;
               nxt_lat_R   = cur_bit;
            end else begin
               nxt_lat_clk = 1'b1;
               nxt_lat_D   = cur_bit;
            end
         end
         default: nxt_busy = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (R) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         clr_settle <= 1'b0;
         mode_r     <= 2'd0;
         pat_r      <= 8'd0;
         idx        <= 3'd0;
         captured   <= 8'd0;
         fail_count <= 4'd0;
         pass       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         lat_clk    <= 1'b1;
         lat_S      <= 1'b1;
         lat_R      <= 1'b1;
         lat_D      <= 1'b0;
         lat_rst    <= 1'b0;
      end else begin
         state      <= nxt_state;
         cnt        <= nxt_cnt;
         clr_settle <= nxt_clr_settle;
         mode_r     <= nxt_mode;
         pat_r      <= nxt_pat;
         idx        <= nxt_idx;
         captured   <= nxt_captured;
         fail_count <= nxt_fail;
         pass       <= nxt_pass;
         busy       <= nxt_busy;
         done       <= nxt_done;
         lat_clk    <= nxt_lat_clk;
         lat_S      <= nxt_lat_S;
         lat_R      <= nxt_lat_R;
         lat_D      <= nxt_lat_D;
         lat_rst    <= nxt_lat_rst;
      end
   end

endmodule
